// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide
// with HI/LO result registers and a fixed WIDTH+1 cycle latency.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_neg_a, r_neg_b, r_dz;
  logic               r_done, r_div_zero;
  logic [WIDTH-1:0]   r_b, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_accept, w_signed, w_finish;
  logic [WIDTH-1:0]   w_mag1, w_mag2, w_quo, w_rem, w_hi_res, w_lo_res;
  logic [WIDTH:0]     w_sum, w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic [2*WIDTH-1:0] w_step, w_prod;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_finish = (r_state == S_FIX) && !flush;
  assign w_signed = ~op[0];
  assign w_mag1   = (w_signed && operand1[WIDTH-1]) ? -operand1 : operand1;
  assign w_mag2   = (w_signed && operand2[WIDTH-1]) ? -operand2 : operand2;

  // State register and step counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      r_state <= w_state_nxt;
      if (w_accept)               r_cnt <= '0;
      else if (r_state == S_CALC) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = S_CALC;
      S_CALC: begin
        if (flush)                          w_state_nxt = S_IDLE;
        else if (r_cnt == CW'(WIDTH - 1))   w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One radix-2 step plus the sign-corrected results presented at FIX.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff  = {1'b0, w_shift} - {2'b00, r_b};
    if (r_is_div)
      w_step = w_diff[WIDTH+1] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                               : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
    else
      w_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

    w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    w_quo  = r_acc[WIDTH-1:0];
    w_rem  = r_acc[2*WIDTH-1:WIDTH];
    if (r_is_div) begin
      // With a zero divisor the remainder is |dividend|, so restoring its sign yields operand1.
      w_hi_res = r_neg_a ? -w_rem : w_rem;
      w_lo_res = r_dz ? '1 : ((r_neg_a ^ r_neg_b) ? -w_quo : w_quo);
    end else begin
      w_hi_res = w_prod[2*WIDTH-1:WIDTH];
      w_lo_res = w_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc      <= '0;
      r_b        <= '0;
      r_is_div   <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_dz       <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_is_div <= op[1];
        r_neg_a  <= w_signed & operand1[WIDTH-1];
        r_neg_b  <= w_signed & operand2[WIDTH-1];
        r_dz     <= op[1] && (operand2 == '0);
        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_mag1 : w_mag2)};
        r_b      <= op[1] ? w_mag2 : w_mag1;
      end else if (r_state == S_CALC) begin
        r_acc <= w_step;
      end
      if (w_finish) begin
        r_hi       <= w_hi_res;
        r_lo       <= w_lo_res;
        r_div_zero <= r_dz;
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule
